bcd_decode_arbiter: RTL and testbench
=====================================

Name: bcd_decode_arbiter

Overview:
Round-robin arbiter and sequencer that shares one BCD-to-decimal decoder between NUM_REQ requesters. Each requester presents a 4-bit BCD digit with a request. The block grants one requester at a time, decodes its digit to a 10-bit one-hot code, and delivers the result downstream over a valid/ready handshake. Invalid codes (10-15) produce an all-zero output and an error flag. The block sits between the digit producers (counters, keypad encoders) and the display/indicator driver.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2-8.
SRC_W, $clog2(NUM_REQ), width of the source-index field; derived, not overridden.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req  input  NUM_REQ  per-requester request; held high until its gnt pulse.
d_in  input  4*NUM_REQ  packed BCD digits; requester i uses d_in[4*i+3:4*i]. Must be stable while req[i] is high.
gnt  output  NUM_REQ  one-hot, single-cycle pulse when a requester's digit is captured.
y_valid  output  1  decoded result available.
y  output  10  one-hot decimal code; bit k set for digit k; all zero for invalid input.
y_err  output  1  captured digit was 10-15.
y_src  output  SRC_W  index of the requester whose digit is in y.
y_ready  input  1  downstream accepts y when y_valid && y_ready.

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, y_valid=0, y=0, y_err=0, y_src=0, state=IDLE, priority pointer=0 (requester 0 highest). Releasing reset takes effect at the next rising edge.
- States:
  - IDLE: y_valid=0.
  - HOLD: y_valid=1, output registers stable.
- IDLE, any req high: grant the first requester at or after the pointer, searching upward and wrapping. Same edge:
  - capture the decoded d_in slice into y, y_err, y_src;
  - pulse gnt[winner] for exactly that cycle;
  - set pointer = (winner+1) mod NUM_REQ;
  - go to HOLD.
- IDLE, no req: stay; outputs unchanged (y_valid=0).
- HOLD, y_ready=0: all outputs held stable; gnt=0; new requests ignored.
- HOLD, y_ready=1: transfer completes. If any req is high in that cycle, perform the next arbitration on the same edge and stay in HOLD (back-to-back, one result per cycle). Otherwise go to IDLE with y_valid=0.
- A requester whose gnt pulses is not eligible in that cycle. It must drop req or present the next digit; req still high the following cycle is a new request.
- Latency: req high in cycle N with the block free gives y_valid=1 in cycle N+1.
- Throughput: 1 result per cycle with y_ready tied high.
- Decode rule: digit 0-9 gives y = 1<<digit and y_err=0. Digit 10-15 gives y=0 and y_err=1. The error result is still delivered and handshaked normally.
- Fairness: with all NUM_REQ requesters continuously requesting, each is granted exactly once every NUM_REQ grants.
- Pointer wrap: winner NUM_REQ-1 sets the pointer to 0.
- Reset mid-transfer: any held result is discarded and nothing is re-delivered. Requesters re-arbitrate from pointer 0.
- y, y_err and y_src are only meaningful while y_valid=1. Their values in IDLE keep the last delivered result.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W=4, DEC_W=10, BCD_MAX=9;
  - typedef bcd_t (logic [3:0]) and dec_t (logic [9:0]);
  - state enum {IDLE, HOLD}.
- Natural sub-module: the existing combinational decoder_bcd2decimal, one instance fed by the muxed winner digit. Its output is registered here.
- Round-robin priority search stays inline, as a function or loop in the arbiter.

Test Plan:
- Reset then single request: req=4'b0100, d_in[11:8]=4'd7, y_ready=1 -> gnt=4'b0100 for one cycle; next cycle y_valid=1, y=10'b0010000000, y_src=2, y_err=0.
- Invalid code: req[1]=1, digit=4'd12 -> y=0, y_err=1, y_src=1, delivered with a normal handshake.
- Full contention, y_ready=1: req=4'b1111 held, digits 3,5,8,9 -> grant order 0,1,2,3,0; y sequence bit3, bit5, bit8, bit9, bit3; one result per cycle.
- Backpressure: y_ready=0 for 5 cycles after y_valid -> y, y_src, y_err stable and gnt=0 throughout. y_ready=1 -> completes, next grant on the same edge.
- Wrap and fairness: grant requester 3 first, then assert req=4'b1001 -> requester 0 granted before requester 3 again.
- Async reset mid-HOLD: drop rst_n between edges while y_valid=1 -> y_valid=0 and y=0 immediately. After release, req=4'b1010 grants requester 1 first.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD decode arbiter slice.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam int DEC_W   = 10;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [DIGIT_W-1:0] bcd_t;
  typedef logic [DEC_W-1:0]   dec_t;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  function automatic logic is_bcd(bcd_t d);
    return (d <= BCD_MAX);
  endfunction
endpackage

// File: rtl/decoder_bcd2decimal.sv
// Combinational BCD to one-hot decimal decoder; codes above 9 give zero plus an error flag.
module decoder_bcd2decimal
  import bcd_pkg::*;
(
  input  bcd_t bcd_i,
  output dec_t dec_o,
  output logic err_o
);

  // Decode one digit.
  always_comb begin
    dec_o = '0;
    err_o = 1'b0;
    if (is_bcd(bcd_i)) begin
      dec_o = dec_t'(1'b1) << bcd_i;
    end else begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_decode_arbiter.sv
// Round-robin arbiter sharing one BCD decoder between NUM_REQ requesters,
// with a registered valid/ready result stage.
module bcd_decode_arbiter
  import bcd_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [4*NUM_REQ-1:0]     d_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     y_valid,
  output logic [9:0]               y,
  output logic                     y_err,
  output logic [SRC_W-1:0]         y_src,
  input  logic                     y_ready
);

  state_t             state_q;
  logic [SRC_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               y_valid_q;
  dec_t               y_q;
  logic               y_err_q;
  logic [SRC_W-1:0]   y_src_q;

  bcd_t               digits_s [NUM_REQ];
  logic [NUM_REQ-1:0] elig_s;
  logic               found_s;
  logic [SRC_W-1:0]   win_s;
  logic [SRC_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic               take_s;
  dec_t               dec_s;
  logic               dec_err_s;

  // Split the packed digit bus into per-requester digits.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      digits_s[i] = d_in[DIGIT_W*i +: DIGIT_W];
    end
  end

  // A requester being granted this cycle is masked so its held req is not re-granted.
  assign elig_s = req & ~gnt_q;

  // Round-robin search starting at the pointer, wrapping upward.
  always_comb begin
    logic [SRC_W:0] idx;
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (idx >= (SRC_W+1)'(NUM_REQ)) begin
        idx = idx - (SRC_W+1)'(NUM_REQ);
      end else begin
        idx = idx;
      end
      if (!found_s && elig_s[idx[SRC_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx[SRC_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Decide whether a new capture happens on this edge, and its side effects.
  always_comb begin
    take_s = 1'b0;
    gnt_d  = '0;
    ptr_d  = '0;
    case (state_q)
      IDLE:    take_s = found_s;
      HOLD:    take_s = found_s & y_ready;
      default: take_s = 1'b0;
    endcase
    if (take_s) begin
      gnt_d[win_s] = 1'b1;
    end else begin
      gnt_d = '0;
    end
    if (win_s == SRC_W'(NUM_REQ-1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_s + SRC_W'(1);
    end
  end

  decoder_bcd2decimal u_dec (
    .bcd_i (digits_s[win_s]),
    .dec_o (dec_s),
    .err_o (dec_err_s)
  );

  // Sequencer: captures the winner's decoded digit and holds it until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
      y_err_q   <= 1'b0;
      y_src_q   <= '0;
    end else begin
      gnt_q <= gnt_d;
      if (take_s) begin
        state_q   <= HOLD;
        ptr_q     <= ptr_d;
        y_valid_q <= 1'b1;
        y_q       <= dec_s;
        y_err_q   <= dec_err_s;
        y_src_q   <= win_s;
      end else if (state_q == HOLD && y_ready) begin
        state_q   <= IDLE;
        y_valid_q <= 1'b0;
      end else begin
        state_q   <= state_q;
        y_valid_q <= y_valid_q;
      end
    end
  end

  assign gnt     = gnt_q;
  assign y_valid = y_valid_q;
  assign y       = y_q;
  assign y_err   = y_err_q;
  assign y_src   = y_src_q;

endmodule

// File: tb/tb_bcd_decode_arbiter.sv
// Directed self-checking bench for bcd_decode_arbiter (NUM_REQ=4).
module tb_bcd_decode_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] d_in;
  logic [3:0]  gnt;
  logic        y_valid;
  logic [9:0]  y;
  logic        y_err;
  logic [1:0]  y_src;
  logic        y_ready;

  int checks = 0;
  int errors = 0;

  bcd_decode_arbiter #(.NUM_REQ(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .d_in    (d_in),
    .gnt     (gnt),
    .y_valid (y_valid),
    .y       (y),
    .y_err   (y_err),
    .y_src   (y_src),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt, input logic e_vld,
                         input logic [9:0] e_y, input logic e_err, input logic [1:0] e_src);
    chk({tag, ".gnt"},   32'(gnt),     32'(e_gnt));
    chk({tag, ".valid"}, 32'(y_valid), 32'(e_vld));
    chk({tag, ".y"},     32'(y),       32'(e_y));
    chk({tag, ".err"},   32'(y_err),   32'(e_err));
    chk({tag, ".src"},   32'(y_src),   32'(e_src));
  endtask

  initial begin
    logic [9:0] exp_y [5];
    logic [1:0] exp_s [5];
    exp_y[0] = 10'h008; exp_y[1] = 10'h020; exp_y[2] = 10'h100;
    exp_y[3] = 10'h200; exp_y[4] = 10'h008;
    exp_s[0] = 2'd0; exp_s[1] = 2'd1; exp_s[2] = 2'd2; exp_s[3] = 2'd3; exp_s[4] = 2'd0;

    rst_n = 1'b0; req = 4'b0000; d_in = 16'h0000; y_ready = 1'b0;
    step(); step();
    chk_out("reset", 4'b0000, 1'b0, 10'h000, 1'b0, 2'd0);
    rst_n = 1'b1;
    step();

    // Single request from requester 2, digit 7
    req = 4'b0100; d_in = 16'h0700; y_ready = 1'b1;
    step();
    chk_out("single", 4'b0100, 1'b1, 10'h080, 1'b0, 2'd2);
    req = 4'b0000;
    step();
    chk_out("single_done", 4'b0000, 1'b0, 10'h080, 1'b0, 2'd2);

    // Invalid code from requester 1
    req = 4'b0010; d_in = 16'h00C0;
    step();
    chk_out("invalid", 4'b0010, 1'b1, 10'h000, 1'b1, 2'd1);
    req = 4'b0000;
    step();
    chk("invalid_done.valid", 32'(y_valid), 32'd0);

    // Wrap: requester 3 first, then 0 wins over 3
    req = 4'b1000; d_in = 16'h4000;
    step();
    chk_out("wrap3", 4'b1000, 1'b1, 10'h010, 1'b0, 2'd3);
    req = 4'b0000;
    step();
    req = 4'b1001; d_in = 16'h4001;
    step();
    chk_out("wrap0", 4'b0001, 1'b1, 10'h002, 1'b0, 2'd0);
    req = 4'b1000;
    step();
    chk_out("wrap3b", 4'b1000, 1'b1, 10'h010, 1'b0, 2'd3);
    req = 4'b0000;
    step();
    chk("wrap_done.valid", 32'(y_valid), 32'd0);

    // Full contention, pointer now 0
    req = 4'b1111; d_in = 16'h9853;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("rr%0d", i), 4'(1 << exp_s[i]), 1'b1, exp_y[i], 1'b0, exp_s[i]);
    end
    req = 4'b0000;
    step();
    chk("rr_done.valid", 32'(y_valid), 32'd0);

    // Backpressure, pointer now 1
    req = 4'b0100; d_in = 16'h0600; y_ready = 1'b0;
    step();
    chk_out("bp_grant", 4'b0100, 1'b1, 10'h040, 1'b0, 2'd2);
    req = 4'b0001; d_in = 16'h0602;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("bp_hold%0d", i), 4'b0000, 1'b1, 10'h040, 1'b0, 2'd2);
    end
    y_ready = 1'b1;
    step();
    chk_out("bp_next", 4'b0001, 1'b1, 10'h004, 1'b0, 2'd0);
    req = 4'b0000;
    step();
    chk("bp_done.valid", 32'(y_valid), 32'd0);

    // Async reset while holding a result
    req = 4'b0010; d_in = 16'h0050; y_ready = 1'b0;
    step();
    chk_out("rst_pre", 4'b0010, 1'b1, 10'h020, 1'b0, 2'd1);
    req = 4'b0000;
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 4'b0000, 1'b0, 10'h000, 1'b0, 2'd0);
    @(negedge clk);
    req = 4'b1010; d_in = 16'h8050; y_ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk_out("rst_first", 4'b0010, 1'b1, 10'h020, 1'b0, 2'd1);
    req = 4'b1000;
    step();
    chk_out("rst_second", 4'b1000, 1'b1, 10'h100, 1'b0, 2'd3);
    req = 4'b0000;
    step();
    chk("rst_done.valid", 32'(y_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
